// File: rtl/alfa_cod.sv
// Note-key encoder with debounce: priority-encodes the pressed key plus the sharp key into a
// 4-bit code, and accepts a new code only after it has held stable for DEBOUNCE edges.
module alfa_cod #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] teclas,
  input  logic       sustenido,
  output logic       Tom,
  output logic       notas1,
  output logic       notas2,
  output logic       notas3,
  output logic       valido
);

  typedef enum logic {OCIOSO, CONTANDO} state_t;

  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE - 1);

  state_t     state_reg, state_next;
  logic [3:0] s_reg, s_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [3:0] o_reg, o_next;
  logic       valido_reg, valido_next;

  logic [2:0] n_raw;
  logic [3:0] r_code;

  // Scan from the top key down so the lowest-numbered pressed key wins.
  always_comb begin
    n_raw = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (teclas[i]) n_raw = 3'(i + 1);
    end
  end

  // Silence is always code 0000, whatever the sharp key does.
  assign r_code = {(n_raw != 3'd0) & sustenido, n_raw};

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    o_next      = o_reg;
    valido_next = 1'b0;
    s_next      = r_code;
    case (state_reg)
      OCIOSO: begin
        cnt_next = 4'd0;
        if (r_code != o_reg) state_next = CONTANDO;
      end
      CONTANDO: begin
        if (r_code == o_reg) begin
          state_next = OCIOSO;
          cnt_next   = 4'd0;
        end else if (r_code != s_reg) begin
          cnt_next = 4'd0;
        end else if (cnt_reg == CNT_LAST) begin
          o_next      = s_reg;
          state_next  = OCIOSO;
          cnt_next    = 4'd0;
          valido_next = (s_reg != 4'd0);
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = OCIOSO;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= OCIOSO;
      s_reg      <= 4'd0;
      cnt_reg    <= 4'd0;
      o_reg      <= 4'd0;
      valido_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      s_reg      <= s_next;
      cnt_reg    <= cnt_next;
      o_reg      <= o_next;
      valido_reg <= valido_next;
    end
  end

  assign {Tom, notas3, notas2, notas1} = o_reg;
  assign valido = valido_reg;

endmodule

// File: tb/tb_alfa_cod.sv
// Self-checking bench for alfa_cod (DEBOUNCE = 4): vector table plus hand-written corner
// sequences, with a scoreboard queue holding the code expected at each valido strobe.
module tb_alfa_cod;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] teclas;
  logic       sustenido;
  logic       Tom, notas1, notas2, notas3, valido;

  int errors = 0;
  int checks = 0;
  logic [3:0] sb[$];
  logic       prev_valido = 1'b0;

  alfa_cod #(.DEBOUNCE(4)) dut (
    .clock(clock), .reset(reset), .teclas(teclas), .sustenido(sustenido),
    .Tom(Tom), .notas1(notas1), .notas2(notas2), .notas3(notas3), .valido(valido)
  );

  always #5 clock = ~clock;

  wire [3:0] code = {Tom, notas3, notas2, notas1};

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest pending expected code.
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (valido === 1'b1 && prev_valido === 1'b1) begin
        errors++;
        $display("FAIL valido_twice: got 1 on two consecutive cycles expected single strobe");
      end
      if (valido === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valido: got strobe with code %b expected no strobe", code);
        end else begin
          logic [3:0] e;
          e = sb.pop_front();
          if (code !== e) begin
            errors++;
            $display("FAIL strobe_code: got %b expected %b", code, e);
          end else begin
            $display("strobe code=%b ok", code);
          end
        end
      end
    end
    prev_valido = valido;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [6:0] t;
    logic       s;
    logic [3:0] exp_code;
    logic       exp_strobe;
  } vec_t;

  vec_t vecs[10];

  initial begin
    reset = 1'b1;
    teclas = 7'd0;
    sustenido = 1'b0;
    step(3);
    check("reset_code", code, 4'b0000);
    check("reset_valido", {3'b0, valido}, 4'b0000);
    reset = 1'b0;

    // Exact latency: Do held before edge 1, visible after edge 5 only.
    teclas = 7'b0000001;
    sb.push_back(4'b0001);
    for (int e = 1; e <= 6; e++) begin
      step(1);
      check($sformatf("lat_code_e%0d", e), code, (e >= 5) ? 4'b0001 : 4'b0000);
      check($sformatf("lat_valido_e%0d", e), {3'b0, valido}, (e == 5) ? 4'b0001 : 4'b0000);
    end
    $display("latency Do code=%b", code);

    // Alternating Mi/Do every 2 edges must never displace the accepted Do.
    for (int i = 0; i < 10; i++) begin
      teclas = (i % 2 == 0) ? 7'b0000100 : 7'b0000001;
      step(2);
      check($sformatf("toggle_%0d", i), code, 4'b0001);
    end
    teclas = 7'b0000001;
    step(2);
    $display("toggle Mi/Do code=%b", code);

    // Release to idle, then a 2-edge Re glitch must be rejected.
    teclas = 7'd0;
    step(6);
    check("release_do", code, 4'b0000);
    teclas = 7'b0000010;
    step(2);
    teclas = 7'd0;
    step(8);
    check("glitch_re", code, 4'b0000);
    $display("glitch Re code=%b", code);

    vecs[0] = '{7'b0000001, 1'b0, 4'b0001, 1'b1};
    vecs[1] = '{7'b1000000, 1'b1, 4'b1111, 1'b1};
    vecs[2] = '{7'b0000000, 1'b1, 4'b0000, 1'b0};
    vecs[3] = '{7'b0110000, 1'b0, 4'b0101, 1'b1};
    vecs[4] = '{7'b0110000, 1'b1, 4'b1101, 1'b1};
    vecs[5] = '{7'b0100100, 1'b0, 4'b0011, 1'b1};
    vecs[6] = '{7'b0000000, 1'b0, 4'b0000, 1'b0};
    vecs[7] = '{7'b1111111, 1'b1, 4'b1001, 1'b1};
    vecs[8] = '{7'b1111111, 1'b1, 4'b1001, 1'b0};
    vecs[9] = '{7'b0000000, 1'b0, 4'b0000, 1'b0};
    foreach (vecs[i]) begin
      teclas = vecs[i].t;
      sustenido = vecs[i].s;
      if (vecs[i].exp_strobe) sb.push_back(vecs[i].exp_code);
      step(4);
      check($sformatf("vec%0d_early", i), code,
            (i == 0) ? 4'b0000 : vecs[i-1].exp_code);
      step(2);
      check($sformatf("vec%0d_code", i), code, vecs[i].exp_code);
      check($sformatf("vec%0d_pending", i), 4'(sb.size()), 4'd0);
      $display("vec%0d teclas=%b sust=%b code=%b", i, vecs[i].t, vecs[i].s, code);
    end

    // Reset mid-count discards Fa; full window required after release.
    sustenido = 1'b0;
    teclas = 7'b0001000;
    step(3);
    reset = 1'b1;
    step(1);
    check("rst_mid_code", code, 4'b0000);
    reset = 1'b0;
    sb.push_back(4'b0100);
    for (int e = 1; e <= 5; e++) begin
      step(1);
      check($sformatf("rst_fa_e%0d", e), code, (e == 5) ? 4'b0100 : 4'b0000);
    end
    step(2);
    check("rst_fa_pending", 4'(sb.size()), 4'd0);
    $display("reset mid-count Fa code=%b", code);

    do_reset();
    check("final_reset_code", code, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alfa_cod.md
ALFA_COD -- requirements
Module: alfa_cod

Interface
REQ-001 Parameter DEBOUNCE, default 4, number of consecutive identical samples required to accept a new code; legal range 1..15.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clock.
REQ-004 teclas  input  7  note keys, bit0 = Do ... bit6 = Si; 1 = pressed; asynchronous to nothing (already clock-domain).
REQ-005 sustenido  input  1  tone/sharp key; 1 = pressed.
REQ-006 Tom  output  1  accepted tone bit, registered.
REQ-007 notas1  output  1  accepted note code bit 0 (LSB), registered.
REQ-008 notas2  output  1  accepted note code bit 1, registered.
REQ-009 notas3  output  1  accepted note code bit 2 (MSB), registered.
REQ-010 valido  output  1  one-cycle strobe: a new non-silent code was accepted this cycle.

Function
REQ-011 Raw code R = {T, N}: N = 1 + index of lowest-numbered set bit of teclas (Do=001 ... Si=111); N = 000 when teclas = 0.
REQ-012 Multiple keys pressed: lowest index wins (e.g. teclas = 0100100 -> N = 011).
REQ-013 T = sustenido when N != 000; T forced 0 when N = 000 (silence is always code 0000).
REQ-014 Sample register S captures R every rising edge; counter CNT (4 bits) counts consecutive edges where R equals S.
REQ-015 Output register O = {Tom, notas3, notas2, notas1} changes only through the debounce FSM.
REQ-016 FSM states: OCIOSO (S equals O, CNT held 0) and CONTANDO (S differs from O).
REQ-017 OCIOSO -> CONTANDO on edge where R != O; S <= R, CNT <= 0.
REQ-018 In CONTANDO, edge with R == S and CNT < DEBOUNCE-1: CNT increments.
REQ-019 In CONTANDO, edge with R != S and R != O: S <= R, CNT <= 0 (restart, stay CONTANDO).
REQ-020 In CONTANDO, edge with R == O: return to OCIOSO, CNT <= 0, O unchanged, no valido (glitch rejected).
REQ-021 In CONTANDO, edge with R == S and CNT == DEBOUNCE-1: O <= S, return to OCIOSO; valido = 1 for the following cycle iff S != 0000.
REQ-022 Latency: a raw code held stable from before edge k is visible on outputs after edge k+DEBOUNCE; DEBOUNCE=1 gives update after edge k+1.
REQ-023 Release (R -> 0000) is debounced identically; outputs go to 0000 with valido = 0.
REQ-024 Change between two non-silent codes (e.g. Do -> Re, or Tom toggled) debounced identically and strobes valido.
REQ-025 valido is never high two consecutive cycles; holding a key produces exactly one strobe.
REQ-026 Outputs are glitch-free registered values; no combinational path from teclas/sustenido to any output.

Reset
REQ-027 reset = 1 at a rising edge: O = 0000, valido = 0, S = 0000, CNT = 0, state OCIOSO; overrides all other activity.
REQ-028 Reset asserted mid-count discards the pending code; after release a held key requires a full DEBOUNCE window again.
REQ-029 While reset held, inputs are ignored and outputs stay 0000/0.

Verification (DEBOUNCE = 4)
REQ-030 Reset, then teclas = 0000001, sustenido = 0 held before edge 1 -> outputs 0001 (Tom=0,notas=001) after edge 5, valido = 1 only in cycle after edge 5.
REQ-031 teclas = 1000000, sustenido = 1 held -> outputs 1111 after 5 edges, one valido; release both -> 0000 after 5 edges, no valido.
REQ-032 From idle 0000, press Re for 2 edges then release -> outputs stay 0000, valido never asserts.
REQ-033 Hold Do, then toggle Mi/Do alternately every 2 edges for 20 edges -> outputs stay 0001, no valido.
REQ-034 teclas = 0110000 (Sol+La) -> outputs 0101 (Sol wins), one valido.
REQ-035 Hold Fa for 3 edges, assert reset one edge, keep Fa held -> outputs 0000 through reset, then 0100 exactly 5 edges after reset deasserted.
